// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_*  : 3-bit operation codes sampled while idle
//   state_t : serialiser FSM state encoding
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/universal_shift_register_if.sv
// Bus bundle for the universal shift register.
//   mode/data_in/serial_in/start : producer -> register
//   data_out/serial_out/busy/done : register -> consumer
// master drives the controls, slave is the register itself.
interface usr_if #(
  parameter int WIDTH = 8
) ();

  logic [2:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output mode, data_in, serial_in, start,
    input  data_out, serial_out, busy, done
  );

  modport slave (
    input  mode, data_in, serial_in, start,
    output data_out, serial_out, busy, done
  );

endinterface

// File: rtl/universal_shift_register_bit_counter.sv
// Loadable down-counter used to time serialiser bursts.
//   clk, reset_n : clock, async active-low reset (clears to 0)
//   load/load_val: synchronous load, wins over dec
//   dec          : decrement by one
//   zero         : count is zero
module bit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with an LSB-first serialiser burst.
//   clk, reset_n : clock, async active-low reset (q <= RESET_VALUE)
//   bus (slave)  : mode/data_in/serial_in/start in,
//                  data_out/serial_out/busy/done out
// While idle, start loads data_in and begins a WIDTH-cycle burst that
// shifts right with serial_in fill; otherwise mode selects the operation.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic   clk,
  input  logic   reset_n,
  usr_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             done_q, done_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;

  bit_counter #(.WIDTH(CW)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (CW'(WIDTH - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      q      <= RESET_VALUE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    done_nxt  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          // start beats mode
          q_nxt     = bus.data_in;
          cnt_load  = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          unique case (bus.mode)
            MODE_HOLD: q_nxt = q;
            MODE_LOAD: q_nxt = bus.data_in;
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], bus.serial_in};
            MODE_SHR:  q_nxt = {bus.serial_in, q[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_nxt = '0;  // zero, not RESET_VALUE
            default:   q_nxt = q;
          endcase
        end
      end
      ST_SHIFT: begin
        // mode/start ignored here; a start mid-burst is dropped
        if (!cnt_zero) begin
          q_nxt   = {bus.serial_in, q[WIDTH-1:1]};
          cnt_dec = 1'b1;
        end else begin
          // WIDTH-1 shifts done: hold so the last bit gets its full cycle
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.data_out   = q;
  assign bus.serial_out = q[0];
  assign bus.busy       = (state == ST_SHIFT);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;
  import shift_pkg::*;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usr_if #(.WIDTH(W)) bus ();

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model: value as an integer, burst tracked as busy cycles left
  int m_q;
  int m_left;
  int m_done;

  task automatic model_reset();
    m_q = int'(RV); m_left = 0; m_done = 0;
  endtask

  task automatic model_edge(logic [2:0] md, logic [7:0] din, logic sin, logic st);
    int s;
    s = int'(sin);
    if (m_left > 0) begin
      m_done = 0;
      if (m_left > 1) m_q = m_q / 2 + s * 128;
      else            m_done = 1;
      m_left = m_left - 1;
    end else begin
      m_done = 0;
      if (st) begin
        m_q = int'(din); m_left = W;
      end else begin
        case (md)
          MODE_LOAD: m_q = int'(din);
          MODE_SHL:  m_q = (m_q * 2 + s) % 256;
          MODE_SHR:  m_q = m_q / 2 + s * 128;
          MODE_ROL:  m_q = (m_q * 2) % 256 + m_q / 128;
          MODE_ROR:  m_q = m_q / 2 + (m_q % 2) * 128;
          MODE_ASR:  m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0);
          MODE_CLR:  m_q = 0;
          default:   m_q = m_q;
        endcase
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".q"},    {24'b0, bus.data_out}, m_q);
    chk({tag, ".sout"}, {31'b0, bus.serial_out}, m_q % 2);
    chk({tag, ".busy"}, {31'b0, bus.busy}, (m_left > 0) ? 1 : 0);
    chk({tag, ".done"}, {31'b0, bus.done}, m_done);
  endtask

  task automatic step(string tag, logic [2:0] md, logic [7:0] din, logic sin, logic st);
    @(negedge clk);
    bus.mode = md; bus.data_in = din; bus.serial_in = sin; bus.start = st;
    @(posedge clk);
    model_edge(md, din, sin, st);
    #1 check_all(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat;
    bus.mode = MODE_HOLD; bus.data_in = '0; bus.serial_in = 1'b0; bus.start = 1'b0;
    model_reset();

    // reset held across edges
    repeat (3) @(posedge clk);
    #1 check_all("rst");
    chk("rst_const", {24'b0, bus.data_out}, 32'hA5);
    @(negedge clk) reset_n = 1'b1;
    step("hold", MODE_HOLD, 8'hFF, 1'b1, 1'b0);
    chk("hold_const", {24'b0, bus.data_out}, 32'hA5);

    // mode ops
    step("load96", MODE_LOAD, 8'h96, 1'b0, 1'b0);
    step("rol", MODE_ROL, 8'h00, 1'b1, 1'b0);
    chk("rol_const", {24'b0, bus.data_out}, 32'h2D);
    step("ror", MODE_ROR, 8'h00, 1'b1, 1'b0);
    chk("ror_const", {24'b0, bus.data_out}, 32'h96);
    step("asr1", MODE_ASR, 8'h00, 1'b0, 1'b0);
    step("asr2", MODE_ASR, 8'h00, 1'b0, 1'b0);
    chk("asr_const", {24'b0, bus.data_out}, 32'hE5);
    step("clr", MODE_CLR, 8'hFF, 1'b1, 1'b0);
    chk("clr_const", {24'b0, bus.data_out}, 32'h00);
    step("load81", MODE_LOAD, 8'h81, 1'b0, 1'b0);
    step("shl", MODE_SHL, 8'h00, 1'b1, 1'b0);
    chk("shl_const", {24'b0, bus.data_out}, 32'h03);
    step("shr", MODE_SHR, 8'h00, 1'b0, 1'b0);
    chk("shr_const", {24'b0, bus.data_out}, 32'h01);

    // burst B4: serial_out shows data_in LSB first across the busy cycles
    pat = 8'hB4;
    step("b0", MODE_LOAD, 8'hB4, 1'b0, 1'b1);
    chk("b_sout0", {31'b0, bus.serial_out}, {31'b0, pat[0]});
    for (int k = 1; k < W; k++) begin
      step("b", MODE_HOLD, 8'h00, 1'b0, 1'b0);
      chk("b_sout", {31'b0, bus.serial_out}, {31'b0, pat[k]});
    end
    step("bend", MODE_HOLD, 8'h00, 1'b0, 1'b0);
    chk("b_done", {31'b0, bus.done}, 32'd1);
    chk("b_final", {24'b0, bus.data_out}, 32'h01);
    step("bpost", MODE_HOLD, 8'h00, 1'b0, 1'b0);
    chk("b_done_once", {31'b0, bus.done}, 32'd0);

    // collision: start + CLR mid-burst are ignored
    step("c0", MODE_HOLD, 8'h5A, 1'b1, 1'b1);
    step("c1", MODE_HOLD, 8'h00, 1'b1, 1'b0);
    step("c2", MODE_CLR, 8'hFF, 1'b1, 1'b1);
    for (int k = 3; k < W; k++) step("c", MODE_CLR, 8'h00, 1'b1, 1'b0);
    step("cend", MODE_HOLD, 8'h00, 1'b1, 1'b0);
    chk("c_done", {31'b0, bus.done}, 32'd1);
    chk("c_final", {24'b0, bus.data_out}, 32'hFE);

    // start during the done cycle is accepted
    step("d0", MODE_HOLD, 8'hC3, 1'b0, 1'b1);
    chk("d_busy", {31'b0, bus.busy}, 32'd1);
    for (int k = 1; k <= W; k++) step("d", MODE_HOLD, 8'h00, 1'b0, 1'b0);
    chk("d_done", {31'b0, bus.done}, 32'd1);

    // reset in the 4th busy cycle aborts without a done pulse
    step("r0", MODE_HOLD, 8'h3C, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) step("r", MODE_HOLD, 8'h00, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b0;
    model_reset();
    #1 check_all("rmid");
    chk("rmid_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1 check_all("rhold");
    @(negedge clk) reset_n = 1'b1;
    step("f0", MODE_HOLD, 8'h69, 1'b1, 1'b1);
    for (int k = 1; k <= W; k++) step("f", MODE_HOLD, 8'h00, 1'b1, 1'b0);
    chk("f_done", {31'b0, bus.done}, 32'd1);
    chk("f_final", {24'b0, bus.data_out}, 32'hFE);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd", 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
